// File: rtl/dft_sched_pkg.sv
// -----------------------------------------------------------------------------
// dft_sched_pkg
// Shared types and constants for the DFT scan-chain unload scheduler.
//   state_t      : sequencer states, 3-bit encoding
//   c_max_chains : upper bound on the number of scan chains
//   c_slice_w    : width of one chain's data slice on dft_output_data
//   c_idx_w      : width of a chain index (enough for c_max_chains)
// -----------------------------------------------------------------------------
package dft_sched_pkg;

   localparam int c_max_chains = 16;
   localparam int c_slice_w    = 32;
   localparam int c_idx_w      = 4;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SELECT     = 3'd1,
      ST_REQ        = 3'd2,
      ST_UNLOAD     = 3'd3,
      ST_COMMIT_ACK = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

endpackage

// File: rtl/dft_prio_pick.sv
// -----------------------------------------------------------------------------
// dft_prio_pick
// Combinational lowest-set-bit finder used to choose the next chain to unload.
// Ports:
//   i_mask : candidate chains, bit i = chain i
//   o_idx  : index of the lowest set bit (0 when none set)
//   o_any  : at least one bit of i_mask is set
// -----------------------------------------------------------------------------
module dft_prio_pick
   import dft_sched_pkg::*;
#(
   parameter int p_w = c_max_chains
) (
   input  logic [p_w-1:0]     i_mask,
   output logic [c_idx_w-1:0] o_idx,
   output logic               o_any
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      o_idx = '0;
      o_any = 1'b0;
      // Scan from the top down so the last hit, i.e. the lowest index, wins.
      for (int i = p_w - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_idx = c_idx_w'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dft_unload_scheduler.sv
// -----------------------------------------------------------------------------
// dft_unload_scheduler
// Unloads the selected scan chains one at a time, lowest index first, and
// writes every captured 32-bit word into a linear register-file window.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start               : one-cycle start pulse, honoured only when idle
//   chain_mask          : chains to unload, sampled at start
//   words_per_chain     : expected words per chain, sampled at start
//   dft_val_op          : one-hot unload request to the current chain
//   dft_op_ack          : chain accepted the request
//   dft_output_strobe   : chain data slice valid
//   dft_output_data     : chain i data on bits [32i+31:32i]
//   dft_op_commit       : chain finished its unload
//   dft_commit_ack      : one-hot, one-cycle commit (or abort) acknowledge
//   rf_wen/wraddr/wdata : register-file write port, one cycle after the strobe
//   busy                : sequencer not idle
//   done                : one-cycle pulse at end of sequence
//   err                 : sticky error, cleared by the next accepted start
//   cur_chain           : index of the chain being served
// -----------------------------------------------------------------------------
module dft_unload_scheduler
   import dft_sched_pkg::*;
#(
   parameter int p_sc_nbr  = 16,
   parameter int p_addr_w  = 8,
   parameter int p_timeout = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [p_sc_nbr-1:0]           chain_mask,
   input  logic [15:0]                   words_per_chain,
   output logic [p_sc_nbr-1:0]           dft_val_op,
   input  logic [p_sc_nbr-1:0]           dft_op_ack,
   input  logic [p_sc_nbr-1:0]           dft_output_strobe,
   input  logic [c_slice_w*p_sc_nbr-1:0] dft_output_data,
   input  logic [p_sc_nbr-1:0]           dft_op_commit,
   output logic [p_sc_nbr-1:0]           dft_commit_ack,
   output logic                          rf_wen,
   output logic [p_addr_w-1:0]           rf_wraddr,
   output logic [c_slice_w-1:0]          rf_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [c_idx_w-1:0]            cur_chain
);

   localparam int c_wd_w = $clog2(p_timeout + 1);

   state_t                r_state;
   state_t                w_next;
   logic [p_sc_nbr-1:0]   r_mask;
   logic [15:0]           r_wpc;
   logic [15:0]           r_word_cnt;
   logic [c_idx_w-1:0]    r_cur;
   // One extra bit: the MSB set means the window is full and writes stop.
   logic [p_addr_w:0]     r_addr;
   logic [c_wd_w-1:0]     r_wd;
   logic                  r_err;
   logic                  r_done;
   logic                  r_rf_wen;
   logic [p_addr_w-1:0]   r_rf_wraddr;
   logic [c_slice_w-1:0]  r_rf_wdata;

   logic [c_idx_w-1:0]    w_pick_idx;
   logic                  w_any;
   logic [p_sc_nbr-1:0]   w_cur_onehot;
   logic                  w_ack_cur;
   logic                  w_strb_cur;
   logic                  w_commit_cur;
   logic [c_slice_w-1:0]  w_slice;
   logic                  w_write;
   logic                  w_wd_expired;
   logic [15:0]           w_cnt_after;

   dft_prio_pick #(
      .p_w    (p_sc_nbr)
   ) u_pick (
      .i_mask (r_mask),
      .o_idx  (w_pick_idx),
      .o_any  (w_any)
   );

   // Only the current chain's handshake and data are ever looked at.
   always_comb begin
      w_cur_onehot = '0;
      w_ack_cur    = 1'b0;
      w_strb_cur   = 1'b0;
      w_commit_cur = 1'b0;
      w_slice      = '0;
      for (int i = 0; i < p_sc_nbr; i++) begin
         if (r_cur == c_idx_w'(i)) begin
            w_cur_onehot[i] = 1'b1;
            w_ack_cur       = dft_op_ack[i];
            w_strb_cur      = dft_output_strobe[i];
            w_commit_cur    = dft_op_commit[i];
            w_slice         = dft_output_data[i*c_slice_w +: c_slice_w];
         end
      end
   end

   assign w_wd_expired = (r_wd == c_wd_w'(p_timeout - 1));
   assign w_write      = (r_state == ST_UNLOAD) && w_strb_cur &&
                         (r_word_cnt < r_wpc) && !r_addr[p_addr_w];
   // Word count including a strobe arriving in the same cycle as commit.
   assign w_cnt_after  = r_word_cnt + 16'(w_write);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = (chain_mask == '0) ? ST_DONE : ST_SELECT;
         end
         ST_SELECT: begin
            w_next = w_any ? ST_REQ : ST_DONE;
         end
         ST_REQ: begin
            if (w_ack_cur)         w_next = ST_UNLOAD;
            else if (w_wd_expired) w_next = ST_COMMIT_ACK;
         end
         ST_UNLOAD: begin
            // A timeout is an abort and goes through the same acknowledge.
            if (w_commit_cur || (w_wd_expired && !w_write)) w_next = ST_COMMIT_ACK;
         end
         ST_COMMIT_ACK: w_next = ST_SELECT;
         ST_DONE:       w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mask      <= '0;
         r_wpc       <= '0;
         r_word_cnt  <= '0;
         r_cur       <= '0;
         r_addr      <= '0;
         r_wd        <= '0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
         r_rf_wen    <= 1'b0;
         r_rf_wraddr <= '0;
         r_rf_wdata  <= '0;
      end else begin
         r_state  <= w_next;
         r_done   <= (r_state == ST_DONE);
         r_rf_wen <= w_write;
         if (w_write) begin
            r_rf_wraddr <= r_addr[p_addr_w-1:0];
            r_rf_wdata  <= w_slice;
            r_addr      <= r_addr + 1'b1;
            r_word_cnt  <= r_word_cnt + 16'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mask <= chain_mask;
                  r_wpc  <= words_per_chain;
                  r_err  <= 1'b0;
                  r_addr <= '0;
               end
            end
            ST_SELECT: begin
               if (w_any) r_cur <= w_pick_idx;
               r_word_cnt <= '0;
               r_wd       <= '0;
            end
            ST_REQ: begin
               if (w_ack_cur)         r_wd  <= '0;
               else if (w_wd_expired) r_err <= 1'b1;
               else                   r_wd  <= r_wd + 1'b1;
            end
            ST_UNLOAD: begin
               if (w_write) r_wd <= '0;
               else         r_wd <= r_wd + 1'b1;
               // Strobe refused: either the chain overran its word budget or
               // the register-file window is full.
               if (w_strb_cur && !w_write) r_err <= 1'b1;
               if (w_commit_cur) begin
                  if (w_cnt_after < r_wpc) r_err <= 1'b1;
               end else if (w_wd_expired && !w_write) begin
                  r_err <= 1'b1;
               end
            end
            ST_COMMIT_ACK: begin
               r_mask <= r_mask & ~w_cur_onehot;
            end
            default: ;
         endcase
      end
   end

   assign dft_val_op     = (r_state == ST_REQ)        ? w_cur_onehot : '0;
   assign dft_commit_ack = (r_state == ST_COMMIT_ACK) ? w_cur_onehot : '0;
   assign rf_wen         = r_rf_wen;
   assign rf_wraddr      = r_rf_wraddr;
   assign rf_wdata       = r_rf_wdata;
   assign busy           = (r_state != ST_IDLE);
   assign done           = r_done;
   assign err            = r_err;
   assign cur_chain      = r_cur;

endmodule

// File: tb/tb_dft_unload_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dft_unload_scheduler
// Directed bench for dft_unload_scheduler with 4 chains, a 4-word register-file
// window and a 16-cycle watchdog, so overflow and timeout are reachable.
// -----------------------------------------------------------------------------
module tb_dft_unload_scheduler;

   localparam int c_nbr = 4;
   localparam int c_aw  = 2;
   localparam int c_to  = 16;

   logic                  clk;
   logic                  reset;
   logic                  start;
   logic [c_nbr-1:0]      chain_mask;
   logic [15:0]           words_per_chain;
   logic [c_nbr-1:0]      dft_val_op;
   logic [c_nbr-1:0]      dft_op_ack;
   logic [c_nbr-1:0]      dft_output_strobe;
   logic [32*c_nbr-1:0]   dft_output_data;
   logic [c_nbr-1:0]      dft_op_commit;
   logic [c_nbr-1:0]      dft_commit_ack;
   logic                  rf_wen;
   logic [c_aw-1:0]       rf_wraddr;
   logic [31:0]           rf_wdata;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [3:0]            cur_chain;

   dft_unload_scheduler #(
      .p_sc_nbr          (c_nbr),
      .p_addr_w          (c_aw),
      .p_timeout         (c_to)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .chain_mask        (chain_mask),
      .words_per_chain   (words_per_chain),
      .dft_val_op        (dft_val_op),
      .dft_op_ack        (dft_op_ack),
      .dft_output_strobe (dft_output_strobe),
      .dft_output_data   (dft_output_data),
      .dft_op_commit     (dft_op_commit),
      .dft_commit_ack    (dft_commit_ack),
      .rf_wen            (rf_wen),
      .rf_wraddr         (rf_wraddr),
      .rf_wdata          (rf_wdata),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .cur_chain         (cur_chain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [c_aw-1:0] addr;
      logic [31:0]     data;
   } wr_t;

   wr_t wr_q[$];
   int  ca_q[$];
   int  done_cnt;
   int  oh_bad;
   bit  val_seen;
   int  n_total;
   int  n_bad;

   // Passive monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rf_wen) wr_q.push_back('{rf_wraddr, rf_wdata});
      for (int i = 0; i < c_nbr; i++)
         if (dft_commit_ack[i]) ca_q.push_back(i);
      if (done) done_cnt++;
      if (dft_val_op != '0) val_seen = 1'b1;
      if ($countones(dft_val_op) > 1 || $countones(dft_commit_ack) > 1) oh_bad++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      ca_q.delete();
      done_cnt = 0;
      val_seen = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      check({tag, "_val"},  32'(dft_val_op),     32'd0);
      check({tag, "_cack"}, 32'(dft_commit_ack), 32'd0);
      check({tag, "_rf"},   {29'd0, rf_wen, rf_wraddr}, 32'd0);
      check({tag, "_wd"},   rf_wdata,            32'd0);
      check({tag, "_st"},   {28'd0, busy, done, err, 1'b0}, 32'd0);
      check({tag, "_cur"},  32'(cur_chain),      32'd0);
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [31:0] ea, input logic [31:0] ed);
      logic [31:0] ga;
      logic [31:0] gd;
      ga = (i < wr_q.size()) ? 32'(wr_q[i].addr) : 32'hFFFF_FFFF;
      gd = (i < wr_q.size()) ? wr_q[i].data      : 32'hFFFF_FFFF;
      check($sformatf("%s_wa%0d", tag, i), ga, ea);
      check($sformatf("%s_wd%0d", tag, i), gd, ed);
   endtask

   task automatic do_start(input logic [c_nbr-1:0] m, input logic [15:0] wpc);
      chain_mask      = m;
      words_per_chain = wpc;
      start           = 1'b1;
      tick();
      start           = 1'b0;
   endtask

   task automatic wait_val(input int idx);
      int n = 0;
      while (dft_val_op[idx] !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check($sformatf("val_seen_c%0d", idx), 32'(dft_val_op[idx]), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
   endtask

   // Plays one chain: ack after 3 request cycles, n_words strobes, commit.
   // err is expected from strobe index err_from on; noisy drives activity on
   // every other chain, which must be ignored.
   task automatic serve(input string tag, input int idx, input int n_words,
                        input logic [31:0] d0, input logic [31:0] step,
                        input int err_from, input bit noisy);
      logic [c_nbr-1:0] me;
      me = c_nbr'(1) << idx;
      wait_val(idx);
      check({tag, "_val_onehot"}, 32'(dft_val_op), 32'(me));
      check({tag, "_cur"},        32'(cur_chain),  32'(idx));
      if (noisy) begin
         dft_op_ack        = ~me;
         dft_output_strobe = ~me;
         dft_op_commit     = ~me;
      end
      tick();
      tick();
      check({tag, "_val_held"}, 32'(dft_val_op), 32'(me));
      dft_output_strobe = '0;
      dft_op_commit     = '0;
      dft_op_ack        = me;
      tick();
      dft_op_ack        = '0;
      check({tag, "_val_drop"}, 32'(dft_val_op), 32'd0);
      for (int w = 0; w < n_words; w++) begin
         dft_output_data                = {c_nbr{32'hDEAD_BEEF}};
         dft_output_data[idx*32 +: 32]  = d0 + step * 32'(w);
         dft_output_strobe              = noisy ? '1 : me;
         dft_op_commit                  = noisy ? ~me : '0;
         tick();
         check($sformatf("%s_err_s%0d", tag, w), 32'(err), (w >= err_from) ? 32'd1 : 32'd0);
      end
      dft_output_strobe = '0;
      dft_op_commit     = me;
      tick();
      dft_op_commit     = '0;
      check({tag, "_cack"}, 32'(dft_commit_ack), 32'(me));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      n_total           = 0;
      n_bad             = 0;
      oh_bad            = 0;
      reset             = 1'b0;
      start             = 1'b0;
      chain_mask        = '0;
      words_per_chain   = '0;
      dft_op_ack        = '0;
      dft_output_strobe = '0;
      dft_output_data   = '0;
      dft_op_commit     = '0;
      clear_logs();
      repeat (3) tick();
      chk_reset_state("rst");
      reset = 1'b1;
      tick();

      // 1: chains 0 and 2, two words each, with noise on the other chains.
      clear_logs();
      do_start(4'h5, 16'd2);
      serve("t1c0", 0, 2, 32'hA0, 32'h10, 99, 1'b1);
      serve("t1c2", 2, 2, 32'hA2, 32'h10, 99, 1'b1);
      wait_done("t1");
      check("t1_err",  32'(err), 32'd0);
      check("t1_nwr",  32'(wr_q.size()), 32'd4);
      chk_wr("t1", 0, 32'd0, 32'hA0);
      chk_wr("t1", 1, 32'd1, 32'hB0);
      chk_wr("t1", 2, 32'd2, 32'hA2);
      chk_wr("t1", 3, 32'd3, 32'hB2);
      check("t1_nca",  32'(ca_q.size()), 32'd2);
      check("t1_ca0",  32'((ca_q.size() > 0) ? ca_q[0] : -1), 32'd0);
      check("t1_ca1",  32'((ca_q.size() > 1) ? ca_q[1] : -1), 32'd2);
      check("t1_ndone", 32'(done_cnt), 32'd1);

      // 2: empty mask goes straight to DONE; done two cycles after start.
      clear_logs();
      chain_mask = '0;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      check("t2_busy1", 32'(busy), 32'd1);
      check("t2_done0", 32'(done), 32'd0);
      tick();
      check("t2_busy0", 32'(busy), 32'd0);
      check("t2_done1", 32'(done), 32'd1);
      tick();
      check("t2_done_off", 32'(done), 32'd0);
      check("t2_no_val",   32'(val_seen), 32'd0);

      // 3: one word too many; only two writes, err after the third strobe.
      clear_logs();
      do_start(4'h1, 16'd2);
      serve("t3", 0, 3, 32'h30, 32'h1, 2, 1'b0);
      wait_done("t3");
      check("t3_nwr", 32'(wr_q.size()), 32'd2);
      chk_wr("t3", 0, 32'd0, 32'h30);
      chk_wr("t3", 1, 32'd1, 32'h31);
      check("t3_err", 32'(err), 32'd1);

      // 4: chain 0 never acks; watchdog aborts it, chain 1 served normally.
      clear_logs();
      do_start(4'h3, 16'd1);
      tick();
      check("t4_req0", 32'(dft_val_op), 32'd1);
      repeat (c_to - 1) tick();
      check("t4_req_last", 32'(dft_val_op), 32'd1);
      check("t4_err_pre",  32'(err), 32'd0);
      tick();
      check("t4_val_drop", 32'(dft_val_op), 32'd0);
      check("t4_abort",    32'(dft_commit_ack), 32'd1);
      check("t4_err",      32'(err), 32'd1);
      serve("t4c1", 1, 1, 32'h11, 32'h0, 0, 1'b0);
      wait_done("t4");
      check("t4_nwr", 32'(wr_q.size()), 32'd1);
      chk_wr("t4", 0, 32'd0, 32'h11);
      check("t4_nca", 32'(ca_q.size()), 32'd2);
      check("t4_ca1", 32'((ca_q.size() > 1) ? ca_q[1] : -1), 32'd1);

      // 5: window of 4 words; words 5 and 6 are dropped, no wrap to 0.
      clear_logs();
      do_start(4'h1, 16'd6);
      serve("t5", 0, 6, 32'hC0, 32'h1, 4, 1'b0);
      wait_done("t5");
      check("t5_nwr", 32'(wr_q.size()), 32'd4);
      chk_wr("t5", 0, 32'd0, 32'hC0);
      chk_wr("t5", 3, 32'd3, 32'hC3);
      check("t5_err", 32'(err), 32'd1);

      // 6: reset mid-sequence; then reset while requesting; then a clean run.
      clear_logs();
      do_start(4'h2, 16'd0);
      wait_val(1);
      dft_op_ack = 4'h2;
      tick();
      dft_op_ack = '0;
      dft_output_strobe = 4'h2;
      tick();
      dft_output_strobe = '0;
      check("t6_err_wpc0", 32'(err), 32'd1);
      check("t6_cur1",     32'(cur_chain), 32'd1);
      tick();
      check("t6_nowr",     32'(wr_q.size()), 32'd0);
      reset = 1'b0;
      tick();
      chk_reset_state("t6u");
      reset = 1'b1;
      do_start(4'h1, 16'd1);
      wait_val(0);
      reset = 1'b0;
      tick();
      check("t6_req_rst_val", 32'(dft_val_op), 32'd0);
      check("t6_req_rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick();
      clear_logs();
      do_start(4'h3, 16'd1);
      serve("t6c0", 0, 1, 32'h60, 32'h0, 99, 1'b0);
      serve("t6c1", 1, 1, 32'h61, 32'h0, 99, 1'b0);
      wait_done("t6");
      check("t6_err", 32'(err), 32'd0);
      chk_wr("t6", 0, 32'd0, 32'h60);
      chk_wr("t6", 1, 32'd1, 32'h61);

      check("onehot", 32'(oh_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dft_unload_scheduler.md
Name: dft_unload_scheduler

Overview:
- Sequences scan-chain unload for the AXI prewrapper DFT side.
- Serves the selected scan chains one at a time in ascending index order.
- Drives the per-chain val_op/op_ack/op_commit/commit_ack handshake and captures strobed 32-bit words.
- Writes captured words to a linear register-file window, with word-count checking and a watchdog.

Parameters:
p_sc_nbr, 16, number of scan chains (1..16)
p_addr_w, 8, register-file write address width; window depth 2**p_addr_w words
p_timeout, 1024, watchdog limit in cycles for any single wait state

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; ignored unless IDLE
chain_mask  in  p_sc_nbr  chains to unload; sampled at start
words_per_chain  in  16  expected words per chain; sampled at start
dft_val_op  out  p_sc_nbr  one-hot operation request to current chain
dft_op_ack  in  p_sc_nbr  chain accepts request
dft_output_strobe  in  p_sc_nbr  data word valid on chain slice
dft_output_data  in  32*p_sc_nbr  chain i data at bits [32i+31:32i]
dft_op_commit  in  p_sc_nbr  chain finished unload
dft_commit_ack  out  p_sc_nbr  one-cycle commit acknowledge
rf_wen  out  1  register-file write strobe
rf_wraddr  out  p_addr_w  write address
rf_wdata  out  32  write data
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of sequence
err  out  1  sticky error; cleared at next accepted start
cur_chain  out  4  index of chain being served

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, state IDLE, counters 0; takes priority over everything, including mid-sequence. dft_val_op drops the next cycle.
- IDLE:
  - On start: latch mask and words_per_chain, clear err, clear address counter, go to SELECT.
  - If start arrives with mask==0: go directly to DONE.
- SELECT (1 cycle): pick the lowest set bit of the remaining mask; set cur_chain; clear the word count; go to REQ. If no bit remains, go to DONE.
- REQ:
  - dft_val_op[cur_chain]=1 and held until dft_op_ack[cur_chain]==1.
  - val_op deasserts in the cycle after ack is seen; go to UNLOAD.
  - Acks from other chains are ignored.
- UNLOAD, per cycle:
  - If strobe[cur] and the word count is below words_per_chain and the address has not overflowed: rf_wen=1 next cycle (registered, latency 1), rf_wdata=slice, rf_wraddr=address counter; address and word count increment.
  - Strobe with word count == words_per_chain: no write, err=1.
  - Address overflow (counter past 2**p_addr_w-1): no write, err=1, no wrap.
  - On commit[cur]: go to COMMIT_ACK. If the same-cycle strobe is present, it is processed first.
  - Commit with word count < words_per_chain: err=1.
- COMMIT_ACK (1 cycle): dft_commit_ack[cur]=1; clear cur bit from the remaining mask; go to SELECT.
- DONE (1 cycle): done=1; go to IDLE.
- Watchdog:
  - Counter resets on entry to REQ and UNLOAD and on every accepted strobe.
  - If it reaches p_timeout: err=1, drop val_op, pulse commit_ack[cur] as abort, skip the chain, continue at SELECT.
- Signals from unselected chains are never acted on.
- start while busy is ignored.
- words_per_chain==0 is legal: any strobe sets err.
- dft_val_op and dft_commit_ack are always one-hot or zero.

Decomposition:
- Shared package dft_sched_pkg:
  - state enum (IDLE, SELECT, REQ, UNLOAD, COMMIT_ACK, DONE), 3-bit encoding.
  - max-chain constant 16 and data slice width 32.
- One sub-module: dft_prio_pick, a combinational lowest-set-bit finder (mask -> index, any). All sequencing stays in the top.

Test Plan:
- mask=16'h0005, wpc=2; each chain acks after 3 cycles, strobes 0xA0+i, 0xB0+i, then commits -> rf writes addr0=0xA0, 1=0xB0, 2=0xA2, 3=0xB2; commit_ack pulses on chains 0 then 2; done one cycle; err=0.
- mask=0, start -> done pulses 2 cycles after start; dft_val_op never asserted; busy high for 1 cycle.
- mask=1, wpc=2; chain strobes 3 words then commits -> only 2 writes; err=1 after the third strobe.
- mask=3, wpc=1; chain 0 never acks, p_timeout=16 -> val_op[0] drops after 16 cycles with abort commit_ack[0]; chain 1 is served normally; err=1; done.
- p_addr_w=2, mask=1, wpc=6 -> writes at addr 0..3 only, err=1, no wrap to 0.
- reset low during UNLOAD with val_op pending -> all outputs 0 next cycle; a new start then sequences from chain 0 with err=0.
